// File: rtl/datapath_pkg.sv
// Shared constants and types for the decade counter datapath.
package datapath_pkg;
  localparam int COUNT_W   = 4;
  localparam int COUNT_MOD = 10;
  localparam int COUNT_MAX = COUNT_MOD - 1;

  typedef logic [COUNT_W-1:0] count_t;
endpackage

// File: rtl/datapath_mod_counter.sv
// Generic modulo-N up-counter with synchronous active-low clear.
import datapath_pkg::*;

module mod_counter #(
  parameter int MOD = COUNT_MOD,
  parameter int W   = COUNT_W
) (
  input  logic         i_clk,
  input  logic         i_clr_n,
  output logic [W-1:0] o_cnt
);
  localparam logic [W-1:0] LP_MAX = W'(MOD - 1);

  logic [W-1:0] r_cnt_q = '0;
  logic         w_wrap;

  // >= rather than == so a corrupted out-of-range value recovers to 0
  assign w_wrap = (r_cnt_q >= LP_MAX);

  always_ff @(posedge i_clk) begin
    if (!i_clr_n)    r_cnt_q <= '0;
    else if (w_wrap) r_cnt_q <= '0;
    else             r_cnt_q <= r_cnt_q + W'(1);
  end

  assign o_cnt = r_cnt_q;
endmodule

// File: rtl/datapath.sv
// Decade counter datapath; DATAPATH_CHECK_EN compiles in simulation-only step checks.
import datapath_pkg::*;

module datapath #(
  parameter int MODULO = COUNT_MOD,
  parameter int WIDTH  = COUNT_W
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count
);
  if (MODULO < 2 || MODULO > 16 || (2 ** WIDTH) < MODULO) begin : g_bad_cfg
    $error("datapath: illegal MODULO/WIDTH combination");
  end

  mod_counter #(
    .MOD (MODULO),
    .W   (WIDTH)
  ) u_cnt (
    .i_clk   (clk),
    .i_clr_n (reset),
    .o_cnt   (count)
  );

`ifdef DATAPATH_CHECK_EN
  localparam logic [WIDTH:0]   LP_MOD = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] r_chk_prev = '0;
  logic             r_chk_rst  = 1'b0;
  logic             r_chk_vld  = 1'b0;

  always_ff @(posedge clk) begin
    r_chk_prev <= count;
    r_chk_rst  <= reset;
    r_chk_vld  <= 1'b1;
  end

  // count here is the result of the previous edge; r_chk_* hold what that edge saw
  always @(posedge clk) begin
    if ({1'b0, count} >= LP_MOD)
      $error("datapath: count %0d out of range", count);
    if (r_chk_vld && !r_chk_rst && count != '0)
      $error("datapath: count %0d not cleared by reset", count);
    if (r_chk_vld && r_chk_rst && r_chk_prev <= LP_MAX &&
        !((count == r_chk_prev + WIDTH'(1)) || (r_chk_prev == LP_MAX && count == '0)))
      $error("datapath: bad step %0d -> %0d", r_chk_prev, count);
  end
`endif
endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed reset/wrap sequence then random reset traffic.
`timescale 1ns/1ps
module tb_datapath;
  localparam int MOD = 10;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] count;

  int n_err = 0;
  int n_chk = 0;
  int mdl   = 0;

  datapath u_dut (
    .clk   (clk),
    .reset (reset),
    .count (count)
  );

  always #1 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // drive reset, take one rising edge, update reference, check at the falling edge
  task automatic tick(input logic r, input string tag);
    reset = r;
    @(posedge clk);
    mdl = r ? (mdl + 1) % MOD : 0;
    @(negedge clk);
    chk(tag, int'(count), mdl);
    chk({tag, "_rng"}, int'(count < 4'(MOD)), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #0.5;
    chk("por", int'(count), 0);

    for (int i = 0; i < 5; i++) tick(1'b0, "rst_hold");
    for (int i = 0; i < 18; i++) tick(1'b1, "run18");
    chk("run18_end", int'(count), 8);

    while (mdl != 6) tick(1'b1, "to6");
    tick(1'b0, "mid_rst");
    chk("mid_rst_zero", int'(count), 0);
    for (int i = 0; i < 15; i++) tick(1'b0, "rst15");

    for (int i = 0; i < 25; i++) begin
      tick(1'b1, "run25");
      if (i == 0) chk("restart1", int'(count), 1);
      if (i == 9) chk("wrap1", int'(count), 0);
    end
    chk("run25_end", int'(count), 5);

    // reset pulsed low strictly between edges must not be seen
    for (int i = 0; i < 4; i++) begin
      reset = 1'b1;
      #0.25 reset = 1'b0;
      #0.25 reset = 1'b1;
      #0.25 chk("glitch_hold", int'(count), mdl);
      tick(1'b1, "glitch_step");
    end

    for (int i = 0; i < 300; i++)
      tick(($urandom_range(7) != 0), "rand");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
